// File: rtl/picosoc_mem_ctrl_pkg.sv
// Shared types for the PicoSoC SRAM front-end: FSM states, SRAM address width
// and the posted-write buffer entry.
package picosoc_mem_pkg;

  localparam int RAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_ACK
  } state_t;

  typedef struct packed {
    logic [RAM_AW-1:0] index;
    logic [3:0]        strb;
    logic [31:0]       data;
    logic              valid;
  } wbuf_entry_t;

endpackage

// File: rtl/picosoc_mem_ctrl_if.sv
// PicoRV32 native memory bus between the CPU (master) and the SRAM front-end (slave).
interface picosoc_mem_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picosoc_mem_ctrl_wbuf.sv
// One-entry posted-write buffer: drains whenever the SRAM port is free of reads
// and merges buffered bytes into read data when the read hits the buffered word.
module picosoc_mem_wbuf
  import picosoc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_accept,
  input  logic              rd_issue,
  input  logic [RAM_AW-1:0] req_index,
  input  logic [3:0]        req_strb,
  input  logic [31:0]       req_data,
  input  logic [31:0]       ram_rdata,
  output logic [3:0]        drain_wen,
  output logic [RAM_AW-1:0] drain_addr,
  output logic [31:0]       drain_wdata,
  output logic [31:0]       rdata_fwd
);

  wbuf_entry_t entry_reg, entry_next;
  logic [3:0]  fwd_strb_reg;
  logic [31:0] fwd_data_reg;
  logic        drain;

  // A read owns the SRAM port in its issue cycle; every other cycle may drain.
  assign drain = entry_reg.valid && !rd_issue;

  always_comb begin
    entry_next = entry_reg;
    if (wr_accept) begin
      entry_next = '{index: req_index, strb: req_strb, data: req_data, valid: 1'b1};
    end else if (drain) begin
      entry_next.valid = 1'b0;
    end
  end

  always_comb begin
    drain_wen   = 4'b0;
    drain_addr  = '0;
    drain_wdata = 32'h0;
    if (drain) begin
      drain_wen   = entry_reg.strb;
      drain_addr  = entry_reg.index;
      drain_wdata = entry_reg.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_reg    <= '0;
      fwd_strb_reg <= 4'b0;
      fwd_data_reg <= 32'h0;
    end else begin
      entry_reg <= entry_next;
      // Forwarding decision is frozen at issue, against the entry as it was then.
      if (rd_issue) begin
        fwd_strb_reg <= (entry_reg.valid && entry_reg.index == req_index) ? entry_reg.strb : 4'b0;
        fwd_data_reg <= entry_reg.data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign rdata_fwd[gi*8 +: 8] = fwd_strb_reg[gi] ? fwd_data_reg[gi*8 +: 8] : ram_rdata[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/picosoc_mem_ctrl.sv
// SRAM front-end for PicoSoC: window decode and single-cycle SRAM sequencing.
// Define PICOSOC_MEM_CTRL_POSTED_WR_EN to enable the posted-write buffer with forwarding.
module picosoc_mem_ctrl
  import picosoc_mem_pkg::*;
#(
  parameter int          WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  picosoc_mem_ctrl_if.slave bus,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [32:0] WIN_BYTES = 33'(WORDS) << 2;

  state_t            state_reg, state_next;
  logic [31:0]       offset;
  logic              hit, rd_hit, wr_hit;
  logic [RAM_AW-1:0] req_index;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       rdata_src;

  assign offset    = bus.mem_addr - BASE_ADDR;
  assign hit       = bus.mem_valid && (bus.mem_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign req_index = offset[RAM_AW+1:2];
  assign rd_hit    = hit && (bus.mem_wstrb == 4'b0);
  assign wr_hit    = hit && (bus.mem_wstrb != 4'b0);

`ifdef PICOSOC_MEM_CTRL_POSTED_WR_EN
  logic [3:0]        drain_wen;
  logic [RAM_AW-1:0] drain_addr;
  logic [31:0]       drain_wdata;

  picosoc_mem_wbuf u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .wr_accept   (state_reg == ST_IDLE && wr_hit),
    .rd_issue    (state_reg == ST_IDLE && rd_hit),
    .req_index   (req_index),
    .req_strb    (bus.mem_wstrb),
    .req_data    (bus.mem_wdata),
    .ram_rdata   (ram_rdata),
    .drain_wen   (drain_wen),
    .drain_addr  (drain_addr),
    .drain_wdata (drain_wdata),
    .rdata_fwd   (rdata_src)
  );
`else
  assign rdata_src = ram_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    ram_wen    = 4'b0;
    ram_addr   = '0;
    ram_wdata  = 32'h0;
`ifdef PICOSOC_MEM_CTRL_POSTED_WR_EN
    ram_wen    = drain_wen;
    ram_addr   = drain_addr;
    ram_wdata  = drain_wdata;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (rd_hit) begin
          state_next = ST_RD_WAIT;
          ram_wen    = 4'b0;
          ram_addr   = req_index;
          ram_wdata  = 32'h0;
        end else if (wr_hit) begin
`ifdef PICOSOC_MEM_CTRL_POSTED_WR_EN
          mem_ready  = 1'b1;
`else
          state_next = ST_WR_ACK;
          ram_wen    = bus.mem_wstrb;
          ram_addr   = req_index;
          ram_wdata  = bus.mem_wdata;
`endif
        end
      end
      ST_RD_WAIT: begin
        state_next = ST_IDLE;
        mem_ready  = 1'b1;
        mem_rdata  = rdata_src;
      end
      ST_WR_ACK: begin
        state_next = ST_IDLE;
        mem_ready  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset kills any acknowledge or SRAM access in the same cycle.
    if (reset) begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      ram_wen   = 4'b0;
      ram_addr  = '0;
      ram_wdata = 32'h0;
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.mem_rdata = mem_rdata;

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
// Directed bench for picosoc_mem_ctrl with a behavioural single-cycle SRAM model.
module tb_picosoc_mem_ctrl;
  import picosoc_mem_pkg::*;

`ifdef PICOSOC_MEM_CTRL_POSTED_WR_EN
  localparam int WLAT = 0;
`else
  localparam int WLAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b1;
  logic [3:0]        ram_wen;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       sram [0:255];

  int total = 0;
  int bad   = 0;

  picosoc_mem_ctrl_if bus ();

  picosoc_mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
      sram[5] <= 32'hDEADBEEF;
      sram[8] <= 32'h55667788;
      ram_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) sram[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= sram[ram_addr[7:0]];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the ack cycle.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      output int lat, output logic [31:0] rdata,
                      output logic [3:0] acc_wen, output logic [RAM_AW-1:0] acc_addr);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    lat = -1;
    rdata = 32'h0;
    acc_wen = 4'hx;
    acc_addr = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        acc_wen  = ram_wen;
        acc_addr = ram_addr;
      end
      if (bus.mem_ready) begin
        lat   = c;
        rdata = bus.mem_rdata;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int                lat;
    logic [31:0]       rdata;
    logic [3:0]        acc_wen;
    logic [RAM_AW-1:0] acc_addr;
    int                cnt_ready;
    int                cnt_wen;

    vecs[0]  = '{32'h14,  32'h0,        4'h0, 32'hDEADBEEF, 1};
    vecs[1]  = '{32'h14,  32'h00AA0000, 4'h4, 32'h0,        WLAT};
    vecs[2]  = '{32'h14,  32'h0,        4'h0, 32'hDEAABEEF, 1};
    vecs[3]  = '{32'h20,  32'h00001234, 4'h3, 32'h0,        WLAT};
    vecs[4]  = '{32'h20,  32'h0,        4'h0, 32'h55661234, 1};
    vecs[5]  = '{32'h0,   32'hAAAA0001, 4'hF, 32'h0,        WLAT};
    vecs[6]  = '{32'h4,   32'hBBBB0002, 4'hF, 32'h0,        WLAT};
    vecs[7]  = '{32'h8,   32'hCCCC0003, 4'hF, 32'h0,        WLAT};
    vecs[8]  = '{32'h0,   32'h0,        4'h0, 32'hAAAA0001, 1};
    vecs[9]  = '{32'h4,   32'h0,        4'h0, 32'hBBBB0002, 1};
    vecs[10] = '{32'h8,   32'h0,        4'h0, 32'hCCCC0003, 1};
    vecs[11] = '{32'h3FC, 32'h7F000000, 4'h8, 32'h0,        WLAT};
    vecs[12] = '{32'h3FC, 32'h000000C3, 4'h1, 32'h0,        WLAT};
    vecs[13] = '{32'h3FD, 32'h0,        4'h0, 32'h7F0000C3, 1};
    vecs[14] = '{32'h6,   32'h0,        4'h0, 32'hBBBB0002, 1};

    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0;

    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
    check("rst_rdata", bus.mem_rdata, 32'h0);
    check("rst_wen", {28'b0, ram_wen}, 32'h0);
    check("rst_addr", {10'b0, ram_addr}, 32'h0);
    check("rst_wdata", ram_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    idle(1);

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rdata, acc_wen, acc_addr);
      $display("vec %0d addr=%h wstrb=%h lat=%0d rdata=%h", i, vecs[i].addr, vecs[i].wstrb, lat, rdata);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].wstrb == 4'b0) begin
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rd_wen", i), {28'b0, acc_wen}, 32'h0);
        check($sformatf("vec%0d_rd_addr", i), {10'b0, acc_addr}, {24'b0, vecs[i].addr[9:2]});
      end else if (WLAT == 1) begin
        check($sformatf("vec%0d_wr_wen", i), {28'b0, acc_wen}, {28'b0, vecs[i].wstrb});
      end
    end

    // Posted data must have reached the SRAM after drain
    idle(3);
    check("sram_word8", sram[8], 32'h55661234);
    check("sram_word255", sram[255], 32'h7F0000C3);

    // Miss at the window end and at the top of the address space
    cnt_ready = 0;
    cnt_wen   = 0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h400;
    bus.mem_wstrb = 4'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_ready) cnt_ready++;
      if (ram_wen != 4'b0) cnt_wen++;
      @(posedge clk);
      #1;
    end
    bus.mem_wstrb = 4'hF;
    bus.mem_wdata = 32'hFFFFFFFF;
    bus.mem_addr  = 32'hFFFF_FFFC;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_ready) cnt_ready++;
      if (ram_wen != 4'b0) cnt_wen++;
      @(posedge clk);
      #1;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0;
    $display("miss ready_cycles=%0d wen_cycles=%0d", cnt_ready, cnt_wen);
    check("miss_ready", 32'(cnt_ready), 32'h0);
    check("miss_wen", 32'(cnt_wen), 32'h0);
    idle(1);

    // Reset in RD_WAIT
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h14;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("rstrd_ready", {31'b0, bus.mem_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstrd_ready_after", {31'b0, bus.mem_ready}, 32'h0);
    check("rstrd_rdata_after", bus.mem_rdata, 32'h0);
    check("rstrd_wen_after", {28'b0, ram_wen}, 32'h0);
    check("rstrd_addr_after", {10'b0, ram_addr}, 32'h0);
    check("rstrd_wdata_after", ram_wdata, 32'h0);
    @(posedge clk);
    #1;
    xfer(32'h14, 32'h0, 4'h0, lat, rdata, acc_wen, acc_addr);
    $display("post-reset read lat=%0d rdata=%h", lat, rdata);
    check("rstrd_next_lat", 32'(lat), 32'd1);
    check("rstrd_next_rdata", rdata, 32'hDEAABEEF);

    // Reset right after a write is accepted
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h30;
    bus.mem_wdata = 32'h12345678;
    bus.mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0;
    @(negedge clk);
    check("rstwr_ready", {31'b0, bus.mem_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
`ifdef PICOSOC_MEM_CTRL_POSTED_WR_EN
    check("rstwr_sram", sram[12], 32'h0);
`else
    check("rstwr_sram", sram[12], 32'h12345678);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picosoc_mem_ctrl.md
# picosoc_mem_ctrl

Bus front-end that sits directly upstream of the on-chip SRAM macro in PicoSoC. It accepts PicoRV32 native memory-interface requests, decodes the SRAM address window, and sequences the single-cycle-latency SRAM port. Its outputs are word address, byte write-enables and write data. It returns read data with a `mem_ready` handshake. An optional single-entry posted-write buffer with read-after-write forwarding removes the write wait state.

## Interface
Parameters:
- `WORDS`, 256: SRAM depth in 32-bit words; must be ≤ 2^22.
- `BASE_ADDR`, 32'h0000_0000: byte base address of the SRAM window; must be 4-byte aligned.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mem_valid`, in, 1: CPU request valid.
- `mem_addr`, in, 32: CPU byte address.
- `mem_wdata`, in, 32: CPU write data.
- `mem_wstrb`, in, 4: byte strobes; 0 = read.
- `mem_ready`, out, 1: transfer complete this cycle.
- `mem_rdata`, out, 32: read data; valid only while `mem_ready` is high.
- `ram_wen`, out, 4: SRAM byte write-enables.
- `ram_addr`, out, 22: SRAM word address.
- `ram_wdata`, out, 32: SRAM write data.
- `ram_rdata`, in, 32: SRAM read data, registered inside the SRAM, one cycle after the address.

## Operation
- **Hit decode:**
  - `hit = mem_valid && BASE_ADDR <= mem_addr < BASE_ADDR + 4*WORDS`.
  - Word index = `(mem_addr - BASE_ADDR) >> 2`, truncated to 22 bits.
  - Low two address bits are ignored.
- **Misses:** never acknowledged. `mem_ready` stays 0 and the SRAM is not touched, so another slave responds.
- **FSM states:** IDLE, RD_WAIT, WR_ACK.
  - IDLE → RD_WAIT on a read hit. `ram_addr` is driven with the index that cycle and `ram_wen = 0`.
  - RD_WAIT → IDLE unconditionally. `mem_ready = 1` and `mem_rdata = ram_rdata`, after forwarding when configured.
  - IDLE → WR_ACK on a write hit (non-posted build). `ram_wen = mem_wstrb`, `ram_wdata = mem_wdata` and `ram_addr` = index, all combinational in IDLE.
  - WR_ACK → IDLE unconditionally, with `mem_ready = 1`.
- **Request hold:** the CPU keeps request fields stable until `mem_ready`. The block samples them only in IDLE.
- **Idle outputs:** when no transfer is in progress, `ram_wen = 0`. `mem_rdata = 0` whenever `mem_ready = 0`.

## Timing
- **Reset values:** state = IDLE; `mem_ready = 0`, `mem_rdata = 0`, `ram_wen = 0`, `ram_addr = 0`, `ram_wdata = 0`; write buffer invalid.
- **Read latency:** request accepted at cycle T, `mem_ready` at T+1. The earliest next accept is T+2.
- **Write latency (non-posted):** SRAM written at edge ending T, `mem_ready` at T+1.
- **Reset mid-transfer:** any in-flight read or write acknowledge is dropped and no `mem_ready` is issued. A write already clocked into the SRAM stays written. A buffered posted write is discarded.
- **Asserting `mem_valid` while not in IDLE:** ignored, since the CPU protocol forbids it.

## Configuration
- **Macro:** `PICOSOC_MEM_CTRL_POSTED_WR_EN`.
- **Without it:** writes use the WR_ACK path above; the buffer logic is absent.
- **With it, writes:**
  - A write hit in IDLE is acknowledged combinationally in the same cycle (`mem_ready = 1` at T) and stored in a one-entry buffer: index, wstrb, wdata, valid.
  - WR_ACK is unused.
- **With it, drain:**
  - The buffer drains to the SRAM in any cycle where no read is issued.
  - A write arriving while the buffer is full drains the old entry on the SRAM port that cycle and captures the new one; no stall.
  - A read issued while the buffer is full takes the SRAM port; the buffer waits.
- **With it, forwarding:** when a read index equals the buffered index, each returned byte with its buffered strobe set comes from buffered data; other bytes come from `ram_rdata`. The comparison uses buffer contents at the issue cycle T.

## Structure
- **Package `picosoc_mem_pkg`:** FSM state enum, `RAM_AW = 22`, and the write-buffer entry struct (index, strobe, data, valid).
- **Sub-module `picosoc_mem_wbuf`:** holds the posted-write entry, drain arbitration and byte-merge forwarding. It is instantiated only under the macro.

## Test plan
- **Read:** preload word 5 = 32'hDEADBEEF; read 0x14 → `mem_ready` exactly one cycle after accept, `mem_rdata` = 32'hDEADBEEF, `ram_wen` stays 0.
- **Byte write:** write 0x14, wstrb 4'b0100, wdata 32'h00AA0000; then read → 32'hDEAABEEF; non-posted ack one cycle after accept.
- **Miss:** request at `BASE_ADDR + 4*WORDS` (0x400 for defaults) held 8 cycles → `mem_ready` never asserts, `ram_wen` = 0 throughout.
- **Posted RAW:**
  - Macro on: write 0x20 wstrb 4'b0011 wdata 32'h00001234 → ready same cycle.
  - Immediately read 0x20 (RAM holds 32'h55667788) → 32'h55661234.
  - The SRAM then holds 32'h55661234 after the drain.
- **Back-to-back writes:** macro on, writes to 0x0, 0x4 and 0x8 on consecutive accepts → each acked same cycle; a final readback gives all three values.
- **Reset mid-read:** assert `reset` in RD_WAIT → no `mem_ready`, all outputs 0 next cycle. A following read completes normally.
